// File: rtl/edge_detector.sv
`timescale 1ns/1ps
// edge_detector: multi-lane rise/fall/any-edge one-clock pulses with saturating per-lane edge counters.
// Optional macro EDGE_SYNC_EN inserts a 2-flop synchronizer ahead of each lane's sample flop.
module edge_detector #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       inp,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    output logic [WIDTH-1:0]       both,
    output logic                   any_rise,
    output logic                   any_fall,
    output logic [WIDTH*CNT_W-1:0] rise_cnt,
    output logic [WIDTH*CNT_W-1:0] fall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] samp_d;
    logic [WIDTH-1:0] samp_q;
    logic [WIDTH-1:0] prev_q;

`ifdef EDGE_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= inp;
            sync2_q <= sync1_q;
        end
    end

    assign samp_d = sync2_q;
`else
    assign samp_d = inp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            prev_q <= '0;
        end else begin
            samp_q <= samp_d;
            prev_q <= samp_q;
        end
    end

    // Pulses come only from flops, so inp glitches between edges never reach the outputs.
    assign rise     = samp_q & ~prev_q;
    assign fall     = ~samp_q & prev_q;
    assign both     = samp_q ^ prev_q;
    assign any_rise = |rise;
    assign any_fall = |fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [CNT_W-1:0] riseCnt_q;
        logic [CNT_W-1:0] riseCnt_d;
        logic [CNT_W-1:0] fallCnt_q;
        logic [CNT_W-1:0] fallCnt_d;

        // Clear wins over a coincident increment; counts stick at all-ones.
        always_comb begin
            riseCnt_d = riseCnt_q;
            fallCnt_d = fallCnt_q;
            if (clr) begin
                riseCnt_d = '0;
                fallCnt_d = '0;
            end else begin
                if (rise[i] && (riseCnt_q != CNT_MAX)) begin
                    riseCnt_d = riseCnt_q + CNT_W'(1'b1);
                end
                if (fall[i] && (fallCnt_q != CNT_MAX)) begin
                    fallCnt_d = fallCnt_q + CNT_W'(1'b1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                riseCnt_q <= '0;
                fallCnt_q <= '0;
            end else begin
                riseCnt_q <= riseCnt_d;
                fallCnt_q <= fallCnt_d;
            end
        end

        assign rise_cnt[i*CNT_W +: CNT_W] = riseCnt_q;
        assign fall_cnt[i*CNT_W +: CNT_W] = fallCnt_q;
    end

endmodule

// File: tb/tb_edge_detector.sv
`timescale 1ns/1ps
// tb_edge_detector: directed self-checking bench for edge_detector (4-lane instance plus a 1-lane 2-bit-counter instance).
module tb_edge_detector;

`ifdef EDGE_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr4  = 1'b0;
    logic        clrS  = 1'b0;
    logic [3:0]  inp4  = 4'b0000;
    logic        inpS  = 1'b0;

    logic [3:0]  rise4, fall4, both4;
    logic        anyRise4, anyFall4;
    logic [31:0] riseCnt4, fallCnt4;

    logic        riseS, fallS, bothS;
    logic        anyRiseS, anyFallS;
    logic [1:0]  riseCntS, fallCntS;

    int total = 0;
    int bad   = 0;

    bit monEn     = 1'b0;
    int riseSeen  = 0;
    int fallSeen  = 0;
    int edgeSeen  = 0;
    int overlap   = 0;

    edge_detector #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .inp(inp4),
        .rise(rise4), .fall(fall4), .both(both4),
        .any_rise(anyRise4), .any_fall(anyFall4),
        .rise_cnt(riseCnt4), .fall_cnt(fallCnt4)
    );

    edge_detector #(.WIDTH(1), .CNT_W(2)) dutS (
        .clk(clk), .rst_n(rst_n), .clr(clrS), .inp(inpS),
        .rise(riseS), .fall(fallS), .both(bothS),
        .any_rise(anyRiseS), .any_fall(anyFallS),
        .rise_cnt(riseCntS), .fall_cnt(fallCntS)
    );

    always #1 clk = ~clk;

    // Tally lane-0 pulse cycles during the free-running toggle test.
    always @(negedge clk) begin
        if (monEn) begin
            if (rise4[0]) riseSeen++;
            if (fall4[0]) fallSeen++;
            if (both4[0]) edgeSeen++;
            if (rise4[0] && fall4[0]) overlap++;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rise: got %b expected 0000", rise4); end
        total++; if (fall4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_fall: got %b expected 0000", fall4); end
        total++; if (both4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_both: got %b expected 0000", both4); end
        total++; if ({anyRise4, anyFall4} !== 2'b00) begin bad++; $display("[TB] FAIL reset_any: got %b expected 00", {anyRise4, anyFall4}); end
        total++; if (riseCnt4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rise_cnt: got %h expected 0", riseCnt4); end
        total++; if (fallCnt4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_fall_cnt: got %h expected 0", fallCnt4); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_toggle();
        @(negedge clk);
        #0.25;
        monEn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #3.5;
            inp4[0] = ~inp4[0];
        end
        repeat (4 + EXTRA) @(negedge clk);
        monEn = 1'b0;
        total++; if (riseSeen !== 8) begin bad++; $display("[TB] FAIL toggle_rise_cycles: got %0d expected 8", riseSeen); end
        total++; if (fallSeen !== 8) begin bad++; $display("[TB] FAIL toggle_fall_cycles: got %0d expected 8", fallSeen); end
        total++; if (edgeSeen !== 16) begin bad++; $display("[TB] FAIL toggle_both_cycles: got %0d expected 16", edgeSeen); end
        total++; if (overlap !== 0) begin bad++; $display("[TB] FAIL toggle_rise_fall_overlap: got %0d expected 0", overlap); end
        total++; if (riseCnt4[7:0] !== 8'd8) begin bad++; $display("[TB] FAIL toggle_rise_cnt: got %0d expected 8", riseCnt4[7:0]); end
        total++; if (fallCnt4[7:0] !== 8'd8) begin bad++; $display("[TB] FAIL toggle_fall_cnt: got %0d expected 8", fallCnt4[7:0]); end
    endtask

    task automatic test_reset_high();
        @(negedge clk);
        rst_n = 1'b0;
        inp4  = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (EXTRA) @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL rsthigh_before: got %b expected 0000", rise4); end
        @(negedge clk);
        total++; if (rise4 !== 4'b0001) begin bad++; $display("[TB] FAIL rsthigh_pulse: got %b expected 0001", rise4); end
        total++; if (anyRise4 !== 1'b1) begin bad++; $display("[TB] FAIL rsthigh_any_rise: got %b expected 1", anyRise4); end
        @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL rsthigh_pulse_end: got %b expected 0000", rise4); end
        repeat (3) @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL rsthigh_held: got %b expected 0000", rise4); end
        total++; if (riseCnt4[7:0] !== 8'd1) begin bad++; $display("[TB] FAIL rsthigh_rise_cnt: got %0d expected 1", riseCnt4[7:0]); end
    endtask

    task automatic test_width4();
        inp4 = 4'b0000;
        repeat (2 + EXTRA) @(negedge clk);
        inp4 = 4'b0101;
        repeat (1 + EXTRA) @(negedge clk);
        total++; if (rise4 !== 4'b0101) begin bad++; $display("[TB] FAIL w4_step1_rise: got %b expected 0101", rise4); end
        total++; if (anyRise4 !== 1'b1) begin bad++; $display("[TB] FAIL w4_step1_any_rise: got %b expected 1", anyRise4); end
        total++; if (fall4 !== 4'b0000) begin bad++; $display("[TB] FAIL w4_step1_fall: got %b expected 0000", fall4); end
        total++; if (anyFall4 !== 1'b0) begin bad++; $display("[TB] FAIL w4_step1_any_fall: got %b expected 0", anyFall4); end
        inp4 = 4'b1010;
        repeat (1 + EXTRA) @(negedge clk);
        total++; if (rise4 !== 4'b1010) begin bad++; $display("[TB] FAIL w4_step2_rise: got %b expected 1010", rise4); end
        total++; if (fall4 !== 4'b0101) begin bad++; $display("[TB] FAIL w4_step2_fall: got %b expected 0101", fall4); end
        total++; if (both4 !== 4'b1111) begin bad++; $display("[TB] FAIL w4_step2_both: got %b expected 1111", both4); end
        total++; if (anyFall4 !== 1'b1) begin bad++; $display("[TB] FAIL w4_step2_any_fall: got %b expected 1", anyFall4); end
        repeat (2) @(negedge clk);
        total++; if (riseCnt4 !== 32'h01010102) begin bad++; $display("[TB] FAIL w4_rise_cnt_pack: got %h expected 01010102", riseCnt4); end
        total++; if (fallCnt4 !== 32'h00010002) begin bad++; $display("[TB] FAIL w4_fall_cnt_pack: got %h expected 00010002", fallCnt4); end
    endtask

    task automatic test_latency();
        inp4 = 4'b1110;
        repeat (EXTRA) @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL latency_early: got %b expected 0000", rise4); end
        @(negedge clk);
        total++; if (rise4 !== 4'b0100) begin bad++; $display("[TB] FAIL latency_pulse: got %b expected 0100", rise4); end
        @(negedge clk);
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL latency_width: got %b expected 0000", rise4); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            inpS = 1'b1;
            repeat (2 + EXTRA) @(negedge clk);
            inpS = 1'b0;
            repeat (2 + EXTRA) @(negedge clk);
        end
        total++; if (riseCntS !== 2'd3) begin bad++; $display("[TB] FAIL sat_rise_cnt: got %0d expected 3", riseCntS); end
        total++; if (fallCntS !== 2'd3) begin bad++; $display("[TB] FAIL sat_fall_cnt: got %0d expected 3", fallCntS); end
        clrS = 1'b1;
        @(negedge clk);
        clrS = 1'b0;
        total++; if (riseCntS !== 2'd0) begin bad++; $display("[TB] FAIL clr_rise_cnt: got %0d expected 0", riseCntS); end
        total++; if (fallCntS !== 2'd0) begin bad++; $display("[TB] FAIL clr_fall_cnt: got %0d expected 0", fallCntS); end
        inpS = 1'b1;
        repeat (1 + EXTRA) @(negedge clk);
        total++; if (riseS !== 1'b1) begin bad++; $display("[TB] FAIL clr_coincident_pulse: got %b expected 1", riseS); end
        clrS = 1'b1;
        @(negedge clk);
        clrS = 1'b0;
        total++; if (riseCntS !== 2'd0) begin bad++; $display("[TB] FAIL clr_priority: got %0d expected 0", riseCntS); end
        repeat (2) @(negedge clk);
        total++; if (riseCntS !== 2'd0) begin bad++; $display("[TB] FAIL clr_priority_after: got %0d expected 0", riseCntS); end
    endtask

    task automatic test_async_reset();
        inp4 = 4'b1111;
        repeat (1 + EXTRA) @(negedge clk);
        total++; if (rise4 !== 4'b0001) begin bad++; $display("[TB] FAIL arst_pulse_before: got %b expected 0001", rise4); end
        #0.5;
        rst_n = 1'b0;
        #0.1;
        total++; if (rise4 !== 4'b0000) begin bad++; $display("[TB] FAIL arst_rise: got %b expected 0000", rise4); end
        total++; if (both4 !== 4'b0000) begin bad++; $display("[TB] FAIL arst_both: got %b expected 0000", both4); end
        total++; if (anyRise4 !== 1'b0) begin bad++; $display("[TB] FAIL arst_any_rise: got %b expected 0", anyRise4); end
        total++; if (riseCnt4 !== 32'h0) begin bad++; $display("[TB] FAIL arst_rise_cnt: got %h expected 0", riseCnt4); end
        total++; if (fallCnt4 !== 32'h0) begin bad++; $display("[TB] FAIL arst_fall_cnt: got %h expected 0", fallCnt4); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_reset_high();
        test_width4();
        test_latency();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_detector.md
Name: edge_detector

Overview:
- Multi-lane synchronous edge detector producing one-clock pulses on rising, falling and either edge of each input lane.
- Per-lane saturating edge counters are provided for event statistics.
- Sits at the boundary between slow or level-type control signals and clocked logic that needs single-cycle event strobes.

Parameters:
- WIDTH, 1, number of independent input lanes (>=1).
- CNT_W, 8, width of each per-lane edge counter (>=1).

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all edge counters.
- inp  input  WIDTH  level inputs, one per lane.
- rise  output  WIDTH  per-lane rising-edge pulse.
- fall  output  WIDTH  per-lane falling-edge pulse.
- both  output  WIDTH  per-lane any-edge pulse.
- any_rise  output  1  OR-reduction of rise.
- any_fall  output  1  OR-reduction of fall.
- rise_cnt  output  WIDTH*CNT_W  per-lane rising-edge counts; lane i occupies bits [i*CNT_W +: CNT_W].
- fall_cnt  output  WIDTH*CNT_W  per-lane falling-edge counts; same packing as rise_cnt.

Behaviour:
- Reset is asynchronous and active-low on rst_n. One clock domain, clk.
- Per lane there are two flops:
  - samp_q captures inp[i] (or the synchronizer output) on every posedge clk.
  - prev_q captures samp_q on every posedge clk.
- While rst_n=0: samp_q, prev_q and all counters are 0. Therefore rise, fall, both, any_rise and any_fall are all 0.
- Edge outputs are combinational from flops only, with no path from inp:
  - rise[i] = samp_q & ~prev_q
  - fall[i] = ~samp_q & prev_q
  - both[i] = samp_q ^ prev_q
- Latency: an input change that is set up before posedge k produces its pulse from edge k until edge k+1. Each pulse is exactly one clk period wide.
- An input held high or low for N>=1 sampled cycles produces exactly one pulse per transition.
- Input changes that occur between two posedges and revert before the next posedge are not seen. No pulse is required.
- After reset release, if inp[i]=1 at the first sampling edge, rise[i] pulses once, because the reset value of samp_q/prev_q is 0. This is intended behaviour.
- rise and fall are never asserted simultaneously on one lane. both = rise | fall.
- Counters:
  - On each posedge, rise_cnt lane i increments by 1 when rise[i]=1. fall_cnt lane i increments by 1 when fall[i]=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - clr=1 forces all counters to 0 on that posedge. clr takes priority over a simultaneous increment.
  - clr does not affect samp_q/prev_q or the pulse outputs.
- Asserting rst_n mid-pulse clears the pulse immediately (asynchronously) and clears all counters.

Optional Feature:
- Macro: EDGE_SYNC_EN.
- Defined:
  - Each lane gets a 2-flop synchronizer (reset to 0) ahead of samp_q. inp may be asynchronous to clk.
  - Pulse latency becomes 3 posedges after the input change: the pulse spans edge k+2 to edge k+3.
- Not defined:
  - inp feeds samp_q directly. inp must be synchronous to clk.
  - Latency is as stated in Behaviour.

Test Plan:
- WIDTH=1, clk period 2, inp starts 0 and toggles every 3.5 time units for 16 toggles. Required: every toggle yields exactly one 1-cycle both pulse. Rising toggles yield rise only; falling toggles yield fall only. After the run, rise_cnt=8 and fall_cnt=8.
- inp=1 held through reset, then rst_n released. Required: a single rise pulse on the first sampling edge, then rise=0 while inp stays 1. rise_cnt=1.
- CNT_W=2, 5 rising edges. Required: rise_cnt saturates at 3. clr pulsed for one cycle gives rise_cnt=0 on the next cycle. A clr coincident with a rise pulse leaves the count at 0.
- WIDTH=4, inp 0000->0101->1010. Required:
  - First step: rise=0101, any_rise=1, fall=0000.
  - Second step: rise=1010, fall=0101, both=1111.
- rst_n driven low while rise=1 between clock edges. Required: rise drops to 0 immediately and counters read 0.
- With EDGE_SYNC_EN defined: a 0->1 step on inp gives its rise pulse exactly 2 cycles later than without the macro, and the pulse is still 1 cycle wide.
